// File: rtl/pcs_pkg.sv
// Shared PCS definitions for the TX scrambler and RX descrambler.
// Holds scrambler polynomial taps, sync header codes and the block payload struct.
package pcs_pkg;

  localparam int unsigned SCR_WIDTH = 58;
  localparam int unsigned SCR_TAP_A = 57;
  localparam int unsigned SCR_TAP_B = 38;
  localparam int unsigned BLK_WIDTH = 64;
  localparam int unsigned HDR_WIDTH = 2;

  localparam logic [HDR_WIDTH-1:0] SYNC_DATA = 2'b01;
  localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = 2'b10;

  typedef struct packed {
    logic [HDR_WIDTH-1:0] hdr;
    logic [BLK_WIDTH-1:0] data;
    logic                 bypass;
    logic                 hdr_err;
  } pcs_blk_t;

  // Only 01 and 10 are legal 64b/66b sync headers.
  function automatic logic hdr_invalid(input logic [HDR_WIDTH-1:0] hdr);
    return (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
  endfunction

endpackage

// File: rtl/pcs_skid_buf.sv
// Two-entry valid/ready register slice (output register + skid register) for pcs_blk_t.
// o_ready is registered and reflects only whether the skid entry is empty.
module pcs_skid_buf
  import pcs_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     i_valid,
  output logic     o_ready,
  input  pcs_blk_t i_blk,
  output logic     o_valid,
  input  logic     i_ready,
  output pcs_blk_t o_blk
);

  logic     r_out_valid;
  logic     r_skid_valid;
  logic     r_in_ready;
  pcs_blk_t r_out_blk;
  pcs_blk_t r_skid_blk;

  logic     w_out_valid_nxt;
  logic     w_skid_valid_nxt;
  pcs_blk_t w_out_blk_nxt;
  pcs_blk_t w_skid_blk_nxt;
  logic     w_in_fire;
  logic     w_out_free;

  assign w_in_fire  = i_valid && r_in_ready;
  assign w_out_free = !r_out_valid || i_ready;

  // Skid contents always take precedence over new input when the output frees up.
  always_comb begin
    w_out_valid_nxt  = r_out_valid;
    w_out_blk_nxt    = r_out_blk;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_blk_nxt   = r_skid_blk;
    if (w_out_free) begin
      if (r_skid_valid) begin
        w_out_valid_nxt  = 1'b1;
        w_out_blk_nxt    = r_skid_blk;
        w_skid_valid_nxt = 1'b0;
      end else if (w_in_fire) begin
        w_out_valid_nxt = 1'b1;
        w_out_blk_nxt   = i_blk;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else if (w_in_fire) begin
      w_skid_valid_nxt = 1'b1;
      w_skid_blk_nxt   = i_blk;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_blk    <= '0;
      r_skid_blk   <= '0;
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      r_out_blk    <= w_out_blk_nxt;
      r_skid_blk   <= w_skid_blk_nxt;
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_out_valid;
  assign o_blk   = r_out_blk;

endmodule

// File: rtl/scrambler_tx.sv
// TX PCS self-synchronising scrambler (x^58 + x^39 + 1), 64 bits per cycle.
// Sync header passes through; a two-entry register slice provides lossless backpressure.
module scrambler_tx
  import pcs_pkg::*;
#(
  parameter logic [SCR_WIDTH-1:0] SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 scr_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HDR_WIDTH-1:0] in_header,
  input  logic [BLK_WIDTH-1:0] in_data,
  input  logic                 in_bypass,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [HDR_WIDTH-1:0] out_header,
  output logic [BLK_WIDTH-1:0] out_data,
  output logic                 out_bypass,
  output logic                 out_hdr_err
);

  logic [SCR_WIDTH-1:0] r_scr_state;
  logic [SCR_WIDTH-1:0] w_state_nxt;
  logic [BLK_WIDTH-1:0] w_scr_data;
  logic                 w_scramble;
  logic                 w_accept;
  pcs_blk_t             w_in_blk;
  pcs_blk_t             w_out_blk;

  // Bit-serial recurrence unrolled over the word; scrambled bits feed back.
  always_comb begin
    w_state_nxt = r_scr_state;
    w_scr_data  = in_data;
    for (int i = 0; i < int'(BLK_WIDTH); i++) begin
      w_scr_data[i] = in_data[i] ^ w_state_nxt[SCR_TAP_A] ^ w_state_nxt[SCR_TAP_B];
      w_state_nxt   = {w_state_nxt[SCR_WIDTH-2:0], w_scr_data[i]};
    end
  end

  assign w_scramble = scr_en && !in_bypass;
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    w_in_blk         = '0;
    w_in_blk.hdr     = in_header;
    w_in_blk.data    = w_scramble ? w_scr_data : in_data;
    w_in_blk.bypass  = in_bypass;
    w_in_blk.hdr_err = hdr_invalid(in_header);
  end

  // State commits only when a scrambled word is actually taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scr_state <= SEED;
    end else if (w_accept && w_scramble) begin
      r_scr_state <= w_state_nxt;
    end
  end

  pcs_skid_buf u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_blk   (w_in_blk),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_blk   (w_out_blk)
  );

  assign out_header  = w_out_blk.hdr;
  assign out_data    = w_out_blk.data;
  assign out_bypass  = w_out_blk.bypass;
  assign out_hdr_err = w_out_blk.hdr_err;

endmodule

// File: tb/tb_scrambler_tx.sv
// Directed bench for scrambler_tx: seed-0 vectors, backpressure scoreboard with an
// independent RX descrambler, alignment markers, header errors and mid-stream reset.
module tb_scrambler_tx;

  localparam logic [57:0] SEED_DEF = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MARKER   = 64'h9076_4700_6F89_B800;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        scr_en;
  logic        in_valid;
  logic [1:0]  in_header;
  logic [63:0] in_data;
  logic        in_bypass;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_bypass, a_out_hdr_err;
  logic [1:0]  a_out_header;
  logic [63:0] a_out_data;
  logic        z_in_ready, z_out_valid, z_out_bypass, z_out_hdr_err;
  logic [1:0]  z_out_header;
  logic [63:0] z_out_data;

  always #5 clk = ~clk;

  scrambler_tx dut (
    .clk(clk), .reset_n(reset_n), .scr_en(scr_en), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_header(in_header), .in_data(in_data),
    .in_bypass(in_bypass), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_header(a_out_header), .out_data(a_out_data), .out_bypass(a_out_bypass),
    .out_hdr_err(a_out_hdr_err)
  );

  scrambler_tx #(.SEED(58'h0)) dut0 (
    .clk(clk), .reset_n(reset_n), .scr_en(scr_en), .in_valid(in_valid),
    .in_ready(z_in_ready), .in_header(in_header), .in_data(in_data),
    .in_bypass(in_bypass), .out_valid(z_out_valid), .out_ready(out_ready),
    .out_header(z_out_header), .out_data(z_out_data), .out_bypass(z_out_bypass),
    .out_hdr_err(z_out_hdr_err)
  );

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] data;
    logic        byp;
    logic        scr;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          n_acc = 0;
  int          n_emit = 0;
  logic [57:0] rx_state;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Receiver-side descrambler: history of received scrambled bits.
  task automatic descr(input logic [63:0] o, output logic [63:0] d);
    for (int i = 0; i < 64; i++) begin
      d[i]     = o[i] ^ rx_state[57] ^ rx_state[38];
      rx_state = {rx_state[56:0], o[i]};
    end
  endtask

  // Book-keep the upcoming edge for dut, advance one cycle, then check stall/occupancy.
  task automatic tick(output logic acc);
    exp_t        e;
    logic [63:0] d;
    logic        stall;
    logic [1:0]  p_hdr;
    logic [63:0] p_data;
    logic        p_byp, p_err;
    acc = in_valid && a_in_ready;
    if (acc) begin
      q.push_back('{hdr: in_header, data: in_data, byp: in_bypass, scr: scr_en});
      n_acc++;
    end
    if (a_out_valid && out_ready) begin
      chk("sb_nonempty", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_emit++;
        if (e.byp || !e.scr) begin
          chk("data_raw", a_out_data, e.data);
        end else begin
          descr(a_out_data, d);
          chk("data_descr", d, e.data);
        end
        chk("hdr", 64'(a_out_header), 64'(e.hdr));
        chk("bypass", 64'(a_out_bypass), 64'(e.byp));
        chk("hdr_err", 64'(a_out_hdr_err), 64'(e.hdr == 2'b00 || e.hdr == 2'b11));
      end
    end
    stall  = a_out_valid && !out_ready;
    p_hdr  = a_out_header;
    p_data = a_out_data;
    p_byp  = a_out_bypass;
    p_err  = a_out_hdr_err;
    @(posedge clk); #1;
    if (stall) begin
      chk("stall_valid", 64'(a_out_valid), 64'd1);
      chk("stall_data", a_out_data, p_data);
      chk("stall_meta", {59'd0, a_out_header, a_out_bypass, a_out_hdr_err},
          {59'd0, p_hdr, p_byp, p_err});
    end
    if (a_in_ready) chk("ready_skid_empty", 64'(n_acc - n_emit <= 1), 64'd1);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_bypass = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_data", a_out_data, 64'd0);
    chk("rst_meta", {61'd0, a_out_header, a_out_bypass}, 64'd0);
    chk("rst_hdr_err", 64'(a_out_hdr_err), 64'd0);
    q.delete();
    n_acc    = 0;
    n_emit   = 0;
    rx_state = SEED_DEF;
    reset_n  = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready_after", 64'(a_in_ready), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   guard;
    reset_n = 1'b0; scr_en = 1'b1; in_valid = 1'b0; in_header = 2'b01;
    in_data = '0; in_bypass = 1'b0; out_ready = 1'b1; rx_state = SEED_DEF;

    // Reset values and seed-0 directed vectors.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready_low", 64'(a_in_ready), 64'd0);
    chk("z_rst_valid", 64'(z_out_valid), 64'd0);
    chk("z_rst_data", z_out_data, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_1cyc", 64'(a_in_ready), 64'd1);
    chk("z_in_ready_1cyc", 64'(z_in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = 64'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("z_zero_valid", 64'(z_out_valid), 64'd1);
      chk("z_zero_data", z_out_data, 64'h0);
    end
    in_data = 64'h1;
    @(posedge clk); #1;
    chk("z_one_data", z_out_data, 64'h0400_0080_0000_0001);
    chk("z_one_hdr", 64'(z_out_header), 64'd1);
    chk("z_one_valid", 64'(z_out_valid), 64'd1);
    chk("z_one_flags", {62'd0, z_out_bypass, z_out_hdr_err}, 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("z_idle_valid", 64'(z_out_valid), 64'd0);

    // Backpressure with markers, header errors and scr_en toggling.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'b1;
      in_data   = {$urandom, $urandom};
      in_header = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
      in_bypass = 1'b0;
      scr_en    = !(k >= 300 && k < 320);
      if (k == 50) in_header = 2'b11;
      if (k == 60) in_header = 2'b00;
      if (k == 100 || k == 250) begin
        in_bypass = 1'b1;
        in_data   = MARKER;
      end
      guard = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        tick(acc);
        guard++;
      end while (!acc && guard < 50);
      chk("accept_bound", 64'(acc), 64'd1);
    end
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    out_ready = 1'b1;
    scr_en    = 1'b1;
    repeat (4) tick(acc);
    chk("drain_empty", 64'(q.size()), 64'd0);

    // Full-rate loopback: one word per cycle.
    for (int k = 0; k < 10000; k++) begin
      in_valid  = 1'b1;
      in_data   = {$urandom, $urandom};
      in_header = 2'b01;
      tick(acc);
      chk("full_rate_acc", 64'(acc), 64'd1);
      chk("full_rate_valid", 64'(a_out_valid), 64'd1);
    end
    in_valid = 1'b0;
    repeat (3) tick(acc);
    chk("loop_drain_empty", 64'(q.size()), 64'd0);

    // Fill output and skid, then reset mid-flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (4) begin
      in_data = {$urandom, $urandom};
      tick(acc);
    end
    chk("skid_full_ready", 64'(a_in_ready), 64'd0);
    chk("skid_full_valid", 64'(a_out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(a_out_valid), 64'd0);
    chk("async_rst_ready", 64'(a_in_ready), 64'd0);
    in_valid = 1'b0;
    q.delete();
    n_acc    = 0;
    n_emit   = 0;
    rx_state = SEED_DEF;
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      chk("no_stale_word", 64'(a_out_valid), 64'd0);
    end
    in_valid  = 1'b1;
    in_data   = 64'hDEAD_BEEF_0123_4567;
    in_header = 2'b10;
    guard = 0;
    do begin
      tick(acc);
      guard++;
    end while (!acc && guard < 10);
    chk("post_rst_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    repeat (3) tick(acc);
    chk("post_rst_emitted", 64'(n_emit), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
